// File: rtl/conv_pkg.sv
// Shared definitions for the convolution partial-sum accumulator:
// FSM state encoding, default lane widths and lane-slicing constants.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_OUT_NUM    = 18;
    localparam int DEF_PSUM_WIDTH = 24;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_BIAS_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    // Lane-packed bus widths; lane 0 sits at the LSBs of every bus.
    localparam int DEF_PSUM_BUS_W = DEF_OUT_NUM * DEF_PSUM_WIDTH;
    localparam int DEF_BIAS_BUS_W = DEF_OUT_NUM * DEF_BIAS_WIDTH;
    localparam int DEF_ACC_BUS_W  = DEF_OUT_NUM * DEF_ACC_WIDTH;
    localparam int DEF_DATA_BUS_W = DEF_OUT_NUM * DEF_DATA_WIDTH;

endpackage

// File: rtl/conv_requant.sv
// One-lane requantiser: round-half-up arithmetic right shift, optional ReLU,
// signed saturation to DATA_WIDTH. Purely combinational.
// Build option: define CONV_ACC_RELU_EN to clamp negative results to zero.
module conv_requant
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [4:0]            shift,
    output logic signed [DATA_WIDTH-1:0] data
);

    // One guard bit so adding the rounding constant can never overflow.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+1)'(1);

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] t;

    // Round, shift, rectify and saturate one lane.
    always_comb begin
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = (ACC_WIDTH+1)'(1) << (shift - 5'd1);
        end
        sum = ext + rnd;
        t   = sum >>> shift;
`ifdef CONV_ACC_RELU_EN
        if (t < 0) begin
            t = '0;
        end
`else
`endif
        if (t > SAT_MAX) begin
            data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (t < SAT_MIN) begin
            data = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            data = t[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_psum_accum.sv
// Multi-pass psum accumulator: sums per-pixel psums over input-channel passes
// in an on-chip buffer, adds per-lane bias on pass 0 and requantises the final
// pass to 8-bit activations. Build option CONV_ACC_RELU_EN (see conv_requant).
//
// Handshakes: a word moves on a channel in any cycle where its valid and ready
// are both high at the rising edge. A producer holds valid and data stable until
// that happens; ready never depends on the producer's valid on the same channel.
module conv_psum_accum
    import conv_pkg::*;
#(
    parameter int OUT_NUM    = DEF_OUT_NUM,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_DEPTH  = 320,
    parameter int ADDR_W     = $clog2(ACC_DEPTH),
    parameter int PASS_W     = 6
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             cfg_start,
    input  logic [PASS_W-1:0]                cfg_pass_num,
    input  logic [ADDR_W:0]                  cfg_pix_num,
    input  logic [4:0]                       cfg_shift,
    input  logic [OUT_NUM*BIAS_WIDTH-1:0]    bias_in,
    input  logic [OUT_NUM*PSUM_WIDTH-1:0]    psum_in,
    input  logic                             psum_valid_in,
    output logic                             psum_ready_out,
    output logic [OUT_NUM*DATA_WIDTH-1:0]    data_out,
    output logic                             data_valid_out,
    input  logic                             data_ready_in,
    output logic                             busy,
    output logic                             done,
    output state_t                           fsm_state
);

    localparam int AB = OUT_NUM * ACC_WIDTH;

    state_t                           state, state_nxt;
    logic [PASS_W-1:0]                pass_cnt, pass_last;
    logic [ADDR_W-1:0]                pix, pix_last, pix_nxt;
    logic [ADDR_W:0]                  pix_eff, pix_eff_m1;
    logic [4:0]                       shift_q;
    logic [OUT_NUM*BIAS_WIDTH-1:0]    bias_q;
    logic                             hs, stall, last_pix, last_pass, first_pass, we, re;
    logic [AB-1:0]                    acc_nxt, acc_q, mem_q, fwd_q, rd_word;
    logic                             fwd_sel, acc_vld;
    logic [OUT_NUM*DATA_WIDTH-1:0]    rq_word;
    logic [AB-1:0]                    mem [ACC_DEPTH];

    assign stall          = data_valid_out && !data_ready_in;
    assign busy           = (state != IDLE);
    assign psum_ready_out = busy && (state == ACCUM) && !stall;
    assign hs             = psum_valid_in && psum_ready_out;
    assign last_pix       = (pix == pix_last);
    assign last_pass      = (pass_cnt == pass_last);
    assign first_pass     = (pass_cnt == '0);
    assign we             = hs && !last_pass;
    assign re             = (state == ACCUM) && (pass_last != '0);
    assign rd_word        = fwd_sel ? fwd_q : mem_q;
    assign fsm_state      = state;

    // Clamp the pixel count into 1..ACC_DEPTH before latching.
    always_comb begin
        pix_eff = cfg_pix_num;
        if (cfg_pix_num == '0) begin
            pix_eff = (ADDR_W+1)'(1);
        end else if (cfg_pix_num > (ADDR_W+1)'(ACC_DEPTH)) begin
            pix_eff = (ADDR_W+1)'(ACC_DEPTH);
        end
        pix_eff_m1 = pix_eff - (ADDR_W+1)'(1);
    end

    // Next pixel index; also the prefetch address, so it holds during a stall.
    always_comb begin
        pix_nxt = pix;
        if (hs) begin
            pix_nxt = last_pix ? '0 : pix + ADDR_W'(1);
        end
    end

    // Per-lane accumulate: bias on the first pass, buffered partial sum after.
    always_comb begin
        acc_nxt = '0;
        for (int l = 0; l < OUT_NUM; l++) begin
            logic [PSUM_WIDTH-1:0] p;
            logic [BIAS_WIDTH-1:0] b;
            logic [ACC_WIDTH-1:0]  base;
            p    = psum_in[l*PSUM_WIDTH +: PSUM_WIDTH];
            b    = bias_q[l*BIAS_WIDTH +: BIAS_WIDTH];
            base = first_pass ? {{(ACC_WIDTH-BIAS_WIDTH){b[BIAS_WIDTH-1]}}, b}
                              : rd_word[l*ACC_WIDTH +: ACC_WIDTH];
            acc_nxt[l*ACC_WIDTH +: ACC_WIDTH] = base + {{(ACC_WIDTH-PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
        end
    end

    // Accumulation RAM with synchronous read; keeps a copy of the write data
    // for the same-address read that happens when a pass is one pixel long.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[pix] <= acc_nxt;
        end
        if (re) begin
            mem_q <= mem[pix_nxt];
            fwd_q <= acc_nxt;
        end
    end

    // Select the forwarded word when the read address matches the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_sel <= 1'b0;
        end else if (re) begin
            fwd_sel <= we && (pix_nxt == pix);
        end
    end

    // Job configuration latch and pass/pixel counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix       <= '0;
            pass_cnt  <= '0;
            pix_last  <= '0;
            pass_last <= '0;
            shift_q   <= '0;
            bias_q    <= '0;
        end else if ((state == IDLE) && cfg_start) begin
            pix       <= '0;
            pass_cnt  <= '0;
            pix_last  <= pix_eff_m1[ADDR_W-1:0];
            pass_last <= (cfg_pass_num == '0) ? '0 : cfg_pass_num - PASS_W'(1);
            shift_q   <= cfg_shift;
            bias_q    <= bias_in;
        end else if (hs) begin
            pix <= pix_nxt;
            if (last_pix) begin
                pass_cnt <= pass_cnt + PASS_W'(1);
            end
        end
    end

    // Two-stage output pipeline (acc register, requant register); frozen on stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_vld        <= 1'b0;
            acc_q          <= '0;
            data_valid_out <= 1'b0;
            data_out       <= '0;
        end else if (!stall) begin
            acc_vld <= hs && last_pass;
            if (hs && last_pass) begin
                acc_q <= acc_nxt;
            end
            data_valid_out <= acc_vld;
            if (acc_vld) begin
                data_out <= rq_word;
            end
        end
    end

    for (genvar g = 0; g < OUT_NUM; g++) begin : g_rq
        conv_requant #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_rq (
            .acc   (acc_q[g*ACC_WIDTH +: ACC_WIDTH]),
            .shift (shift_q),
            .data  (rq_word[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; done marks the handshake of the last output word.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:  if (cfg_start) state_nxt = ACCUM;
            ACCUM: if (hs && last_pix && last_pass) state_nxt = DRAIN;
            DRAIN: begin
                if (data_valid_out && data_ready_in && !acc_vld) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed bench for conv_psum_accum: clock/reset, driver tasks, an in-order
// scoreboard of expected output words and a one-line final report.
module tb_conv_psum_accum;
    import conv_pkg::*;

    localparam int ON    = 18;
    localparam int PW    = 24;
    localparam int BW    = 16;
    localparam int DW    = 8;
    localparam int AD    = 9;
    localparam int PASSW = 6;
    localparam int PB    = ON * PW;
    localparam int BB    = ON * BW;
    localparam int DB    = ON * DW;

    logic              clk;
    logic              rstn;
    logic              cfg_start;
    logic [PASSW-1:0]  cfg_pass_num;
    logic [AD:0]       cfg_pix_num;
    logic [4:0]        cfg_shift;
    logic [BB-1:0]     bias_in;
    logic [PB-1:0]     psum_in;
    logic              psum_valid_in;
    logic              psum_ready_out;
    logic [DB-1:0]     data_out;
    logic              data_valid_out;
    logic              data_ready_in;
    logic              busy;
    logic              done;
    state_t            fsm_state;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [DB-1:0] exp_q[$];

    conv_psum_accum dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_start      (cfg_start),
        .cfg_pass_num   (cfg_pass_num),
        .cfg_pix_num    (cfg_pix_num),
        .cfg_shift      (cfg_shift),
        .bias_in        (bias_in),
        .psum_in        (psum_in),
        .psum_valid_in  (psum_valid_in),
        .psum_ready_out (psum_ready_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .busy           (busy),
        .done           (done),
        .fsm_state      (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PB-1:0] psum_all(input int v);
        logic [PB-1:0] w;
        for (int l = 0; l < ON; l++) w[l*PW +: PW] = v[PW-1:0];
        return w;
    endfunction

    function automatic logic [BB-1:0] bias_all(input int v);
        logic [BB-1:0] w;
        for (int l = 0; l < ON; l++) w[l*BW +: BW] = v[BW-1:0];
        return w;
    endfunction

    function automatic logic [DB-1:0] data_all(input int v);
        logic [DB-1:0] w;
        for (int l = 0; l < ON; l++) w[l*DW +: DW] = v[DW-1:0];
        return w;
    endfunction

    // Reference requant: round half up, arithmetic shift, optional ReLU, saturate.
    function automatic int model_rq(input longint acc, input int sh);
        longint t;
        if (sh > 0) t = (acc + (longint'(1) << (sh - 1))) >>> sh;
        else        t = acc;
`ifdef CONV_ACC_RELU_EN
        if (t < 0) t = 0;
`endif
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return int'(t);
    endfunction

    // driver: pulse cfg_start with a job configuration
    task automatic start_job(input int passes, input int pixels, input int sh, input logic [BB-1:0] b);
        @(negedge clk);
        cfg_pass_num = passes[PASSW-1:0];
        cfg_pix_num  = pixels[AD:0];
        cfg_shift    = sh[4:0];
        bias_in      = b;
        cfg_start    = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        check("busy_rise", busy, 1);
    endtask

    // driver: offer one psum word and wait (bounded) for its handshake
    task automatic send(input logic [PB-1:0] w);
        int n;
        logic got;
        psum_in       = w;
        psum_valid_in = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            #1;
            got = psum_ready_out;
            @(negedge clk);
            n++;
        end
        psum_valid_in = 1'b0;
        check("psum_accept", got, 1);
    endtask

    // wait (bounded) for the done pulse, then confirm the job closed cleanly
    task automatic wait_done(input int budget);
        int n;
        logic got;
        got = 1'b0;
        n = 0;
        while (!got && n < budget) begin
            #1;
            got = done;
            @(negedge clk);
            n++;
        end
        check("done_seen", got, 1);
        #1;
        check("busy_fall", busy, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    // scoreboard: every accepted output word must match the head of exp_q
    always @(negedge clk) begin
        logic [DB-1:0] e;
        #2;
        if (rstn && data_valid_out && data_ready_in) begin
            out_cnt++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 'x;
            check("data_out", data_out, e);
        end
    end

    initial begin
        logic [DB-1:0] e;
        logic [PB-1:0] w;
        logic [BB-1:0] b;
        logic [DB-1:0] held;
        int cnt0;

        // reset
        rstn = 1'b0; cfg_start = 1'b0; cfg_pass_num = '0; cfg_pix_num = '0;
        cfg_shift = '0; bias_in = '0; psum_in = '0; psum_valid_in = 1'b0;
        data_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", psum_ready_out, 0);
        check("rst_data", data_out, 0);
        check("rst_valid", data_valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", fsm_state, IDLE);
        rstn = 1'b1;

        // single pass: bias 10 + psums 1..4, latency of two cycles
        start_job(1, 4, 0, bias_all(10));
        check("t1_ready", psum_ready_out, 1);
        for (int i = 11; i <= 14; i++) exp_q.push_back(data_all(i));
        psum_in = psum_all(1); psum_valid_in = 1'b1;
        @(negedge clk); psum_in = psum_all(2); #1;
        check("t1_no_early_out", data_valid_out, 0);
        @(negedge clk); psum_in = psum_all(3); #1;
        check("t1_valid0", data_valid_out, 1);
        check("t1_out0", data_out, data_all(11));
        @(negedge clk); psum_in = psum_all(4); #1;
        check("t1_out1", data_out, data_all(12));
        @(negedge clk); psum_valid_in = 1'b0; #1;
        check("t1_out2", data_out, data_all(13));
        check("t1_drain_ready", psum_ready_out, 0);
        @(negedge clk); #1;
        check("t1_out3", data_out, data_all(14));
        check("t1_done", done, 1);
        @(negedge clk); #1;
        check("t1_busy_fall", busy, 0);
        check("t1_done_pulse", done, 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // three passes, five pixels: 3*100 - 50 = 250, (250+2)>>>2 = 63
        cnt0 = out_cnt;
        start_job(3, 5, 2, bias_all(-50));
        for (int i = 0; i < 10; i++) send(psum_all(100));
        repeat (3) @(negedge clk);
        check("t2_no_out_early", out_cnt, cnt0);
        for (int i = 0; i < 5; i++) exp_q.push_back(data_all(63));
        for (int i = 0; i < 5; i++) send(psum_all(100));
        wait_done(50);
        check("t2_out_count", out_cnt - cnt0, 5);

        // saturation: +40000>>4 -> 127, -40000>>4 -> -128 (0 with ReLU)
        start_job(1, 2, 4, bias_all(0));
        exp_q.push_back(data_all(127));
        for (int l = 0; l < ON; l++) begin
            w[l*PW +: PW] = (l % 2 == 0) ? 24'sd40000 : -24'sd40000;
`ifdef CONV_ACC_RELU_EN
            e[l*DW +: DW] = (l % 2 == 0) ? 8'h7f : 8'h00;
`else
            e[l*DW +: DW] = (l % 2 == 0) ? 8'h7f : 8'h80;
`endif
        end
        exp_q.push_back(e);
        send(psum_all(40000));
        send(w);
        wait_done(50);

        // one pixel, four passes back to back: 7*4 = 28 needs write forwarding
        start_job(4, 1, 0, bias_all(0));
        exp_q.push_back(data_all(28));
        for (int i = 0; i < 4; i++) send(psum_all(7));
        wait_done(50);

        // zero pass/pixel counts behave as one: 5 + 3 = 8
        start_job(0, 0, 0, bias_all(5));
        exp_q.push_back(data_all(8));
        send(psum_all(3));
        wait_done(50);

        // back-pressure: ready low for five cycles mid-stream
        start_job(1, 8, 0, bias_all(0));
        for (int i = 0; i < 8; i++) exp_q.push_back(data_all(5 * i - 20));
        fork
            begin
                for (int i = 0; i < 8; i++) send(psum_all(5 * i - 20));
            end
            begin
                repeat (4) @(negedge clk);
                data_ready_in = 1'b0;
                @(negedge clk); #1;
                check("bp_ready_drop", psum_ready_out, 0);
                check("bp_valid_hold", data_valid_out, 1);
                held = data_out;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk); #1;
                    check("bp_data_stable", data_out, held);
                    check("bp_ready_low", psum_ready_out, 0);
                end
                @(negedge clk);
                data_ready_in = 1'b1;
            end
        join
        wait_done(50);

        // abort during the second pass, then a fresh two-pass job
        start_job(3, 4, 0, bias_all(7));
        for (int i = 0; i < 6; i++) send(psum_all(1000 + i));
        rstn = 1'b0;
        #1;
        check("abort_data", data_out, 0);
        check("abort_valid", data_valid_out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", psum_ready_out, 0);
        repeat (2) @(negedge clk);
        #1;
        check("abort_data_hold", data_out, 0);
        check("abort_state", fsm_state, IDLE);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();

        for (int l = 0; l < ON; l++) b[l*BW +: BW] = 16'(4 * l - 30);
        start_job(2, 4, 1, b);
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < ON; l++) w[l*PW +: PW] = 24'(10 * p + l);
            send(w);
        end
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < ON; l++) e[l*DW +: DW] = 8'(model_rq(longint'(4 * l - 30 + 10 * p), 1));
            exp_q.push_back(e);
        end
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < ON; l++) w[l*PW +: PW] = 24'(-l);
            send(w);
        end
        wait_done(50);

        // report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
